time_counter: RTL and testbench
===============================

TIME_COUNTER -- requirements
Module: time_counter

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000, clk cycles per second (legal range 2 .. 2^26).
REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port rstn  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port set_mode  input  1  high = time-setting mode, time frozen.
REQ-005 SHALL have port inc_min  input  1  single-cycle pulse, already debounced; +1 minute in set mode.
REQ-006 SHALL have port inc_hour  input  1  single-cycle pulse, already debounced; +1 hour in set mode.
REQ-007 SHALL have port sec_tick  output  1  one-cycle pulse per elapsed second; feeds the alarm sound controller's seconds clock.
REQ-008 SHALL have port min_tick  output  1  one-cycle pulse on a :59 -> :00 seconds rollover.
REQ-009 SHALL have ports hourdec_now, hourone_now, mindec_now, minone_now, secdec_now, secone_now  output  4 each  BCD time digits, registered.

Function
REQ-010 SHALL count a prescaler 0 .. CLK_HZ-1, width $clog2(CLK_HZ), while set_mode=0.
REQ-011 SHALL, on the edge where prescaler = CLK_HZ-1: clear the prescaler, advance seconds by 1, and assert sec_tick for exactly the cycle in which the new digits are visible.
REQ-012 SHALL count seconds as BCD: secone 0..9; on 9, wrap to 0 and increment secdec 0..5; 59 -> 00 carries to minutes.
REQ-013 SHALL assert min_tick in the same cycle as sec_tick whenever seconds wrap 59 -> 00.
REQ-014 SHALL count minutes 00..59 as BCD; 59 -> 00 carries to hours.
REQ-015 SHALL count hours 00..23 as BCD: hourone 0..9 for hourdec 0..1, 0..3 for hourdec 2; 23 -> 00, no carry out.
REQ-016 SHALL roll 23:59:59 -> 00:00:00 on a single sec_tick edge.
REQ-017 SHALL, while set_mode=1: hold the prescaler at 0, hold the seconds at 00, and keep sec_tick and min_tick low.
REQ-018 SHALL, in set mode, on inc_min: minutes +1, wrap 59 -> 00 with no hour carry.
REQ-019 SHALL, in set mode, on inc_hour: hours +1, wrap 23 -> 00.
REQ-020 SHALL apply both increments on the same edge when inc_min and inc_hour coincide.
REQ-021 SHALL ignore inc_min and inc_hour while set_mode=0.
REQ-022 SHALL emit the first sec_tick after set_mode falls exactly CLK_HZ cycles after the first cycle in which set_mode=0 is sampled.
REQ-023 SHALL, on the edge where set_mode rises, clear the seconds to 00 and the prescaler to 0; a coincident pending tick is discarded.
REQ-024 SHALL never present a non-BCD digit or an out-of-range time on any output.

Reset
REQ-025 SHALL, while rstn=0, force all digits to 0 (time 00:00:00), prescaler=0, sec_tick=0 and min_tick=0, independent of clk.
REQ-026 SHALL, after rstn deasserts mid-count, restart timing from prescaler 0; the first sec_tick occurs CLK_HZ cycles later.

Structure
REQ-027 SHALL take bcd_t (4-bit) and the constants SEC_MAX=59, MIN_MAX=59 and HOUR_MAX=23 from shared package alarm_pkg, which the alarm sound controller also uses.
REQ-028 SHALL build seconds, minutes and hours from three instances of one sub-module, bcd_mod_counter: a parameterised two-digit BCD modulo counter with an inc input, a registered digit pair, and a combinational wrap output.

Verification (run with CLK_HZ=4)
REQ-029 SHALL cover: reset release, then 4 cycles -> sec_tick high one cycle, time 00:00:01; 240 cycles total -> min_tick once, time 00:01:00.
REQ-030 SHALL cover: set 23:59, run to 23:59:59, one more second -> 00:00:00 with sec_tick and min_tick high together.
REQ-031 SHALL cover: set_mode=1, 12 inc_min pulses from 00:58 -> 00:10, hours unchanged; 25 inc_hour pulses from 00 -> 01.
REQ-032 SHALL cover: inc_min and inc_hour in the same cycle at 09:59 -> 10:00; the same pulses with set_mode=0 -> no change.
REQ-033 SHALL cover: set_mode rises at prescaler=3 -> no sec_tick, seconds 00; set_mode falls -> sec_tick exactly 4 cycles later.
REQ-034 SHALL cover: rstn pulsed low mid-second at 05:07:33 -> outputs 00:00:00 immediately without a clk edge; next sec_tick 4 cycles after release.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared types and time limits for the clock/alarm block (time counter and alarm sound controller).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alarm_pkg;

  // One BCD digit.
  typedef logic [3:0] bcd_t;

  // Largest legal value of each time field, in decimal.
  localparam int SEC_MAX  = 59;
  localparam int MIN_MAX  = 59;
  localparam int HOUR_MAX = 23;

  // Tens and ones digits of a two-digit decimal value.
  function automatic bcd_t bcd_tens(input int value);
    return bcd_t'(value / 10);
  endfunction

  function automatic bcd_t bcd_ones(input int value);
    return bcd_t'(value % 10);
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo counter: counts 00..MAX and wraps back to 00.
// Latency: digits update on the clk edge that samples inc; wrap is combinational in that same cycle.
// Backpressure: none; every inc pulse is applied, clr wins over inc.
//
// Ports:
//   clk, rstn   clock and asynchronous active-low reset (digits -> 00)
//   clr         synchronous clear to 00, takes priority over inc
//   inc         advance by one on this edge
//   tens, ones  registered BCD digit pair
//   wrap        high when this inc takes the count from MAX back to 00 (carry to the next field)
module bcd_mod_counter
  import alarm_pkg::*;
#(
  parameter int MAX = 59
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       wrap
);

  localparam bcd_t MAX_TENS = bcd_tens(MAX);
  localparam bcd_t MAX_ONES = bcd_ones(MAX);

  logic at_max;

  // A count at or past MAX (never reached from reset, but kept safe) wraps to 00,
  // so the outputs can only ever hold legal BCD in range.
  assign at_max = (tens > MAX_TENS) ||
                  ((tens == MAX_TENS) && (ones >= MAX_ONES));
  assign wrap   = inc & ~clr & at_max;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tens <= 4'd0;
      ones <= 4'd0;
    end else if (clr) begin
      tens <= 4'd0;
      ones <= 4'd0;
    end else if (inc) begin
      if (at_max) begin
        tens <= 4'd0;
        ones <= 4'd0;
      end else if (ones >= 4'd9) begin
        tens <= tens + 4'd1;
        ones <= 4'd0;
      end else begin
        ones <= ones + 4'd1;
      end
    end
  end

endmodule

// File: rtl/time_counter.sv
// Time-of-day counter HH:MM:SS in BCD, driven by a CLK_HZ prescaler, with a set mode for minutes/hours.
// Latency: digits and sec_tick/min_tick change together one clk edge after the prescaler reaches CLK_HZ-1.
// Backpressure: none; inc_min/inc_hour pulses are applied on the edge that samples them (set mode only).
//
// Ports:
//   clk, rstn                 clock and asynchronous active-low reset (time 00:00:00, ticks low)
//   set_mode                  high: time frozen, seconds held at 00, inc_min/inc_hour enabled
//   inc_min, inc_hour         single-cycle debounced pulses, +1 minute / +1 hour in set mode
//   sec_tick                  one-cycle pulse in the cycle new digits of each second are visible
//   min_tick                  one-cycle pulse alongside sec_tick when seconds roll 59 -> 00
//   hourdec_now .. secone_now registered BCD digits of the current time
module time_counter
  import alarm_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       set_mode,
  input  logic       inc_min,
  input  logic       inc_hour,
  output logic       sec_tick,
  output logic       min_tick,
  output logic [3:0] hourdec_now,
  output logic [3:0] hourone_now,
  output logic [3:0] mindec_now,
  output logic [3:0] minone_now,
  output logic [3:0] secdec_now,
  output logic [3:0] secone_now
);

  localparam int            PW         = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);

  logic [PW-1:0] presc;
  logic          sec_due;
  logic          sec_wrap;
  logic          min_wrap;
  logic          min_inc;
  logic          hour_inc;
  logic          hour_wrap_unused;

  // A second elapses on the edge where the prescaler sits at its last count.
  // Gating with set_mode discards a tick that coincides with entering set mode.
  assign sec_due = ~set_mode & (presc == PRESC_LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      presc <= '0;
    end else if (set_mode || sec_due) begin
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // Ticks are registered so they line up with the digit registers they describe.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sec_tick <= 1'b0;
      min_tick <= 1'b0;
    end else begin
      sec_tick <= sec_due;
      min_tick <= sec_wrap;
    end
  end

  // In set mode the buttons drive minutes and hours directly and carries are
  // cut, so minutes wrap 59 -> 00 without touching the hour. While running the
  // buttons are ignored and only the carry chain advances the fields.
  assign min_inc  = set_mode ? inc_min  : sec_wrap;
  assign hour_inc = set_mode ? inc_hour : min_wrap;

  bcd_mod_counter #(
    .MAX (SEC_MAX)
  ) u_sec (
    .clk  (clk),
    .rstn (rstn),
    .clr  (set_mode),
    .inc  (sec_due),
    .tens (secdec_now),
    .ones (secone_now),
    .wrap (sec_wrap)
  );

  bcd_mod_counter #(
    .MAX (MIN_MAX)
  ) u_min (
    .clk  (clk),
    .rstn (rstn),
    .clr  (1'b0),
    .inc  (min_inc),
    .tens (mindec_now),
    .ones (minone_now),
    .wrap (min_wrap)
  );

  // Hours wrap 23 -> 00 with no further carry; the wrap output goes nowhere.
  bcd_mod_counter #(
    .MAX (HOUR_MAX)
  ) u_hour (
    .clk  (clk),
    .rstn (rstn),
    .clr  (1'b0),
    .inc  (hour_inc),
    .tens (hourdec_now),
    .ones (hourone_now),
    .wrap (hour_wrap_unused)
  );

endmodule

// File: tb/tb_time_counter.sv
// Scoreboard bench for time_counter at CLK_HZ=4: stimulus queues each expected second tick.
// Latency: a tick is expected 4 cycles after run/reset release, then every 4 cycles.
// Backpressure: n/a.
module tb_time_counter;

  localparam int CLK_HZ = 4;
  localparam int DAY    = 86400;

  logic       clk      = 1'b0;
  logic       rstn     = 1'b1;
  logic       set_mode = 1'b0;
  logic       inc_min  = 1'b0;
  logic       inc_hour = 1'b0;
  logic       sec_tick;
  logic       min_tick;
  logic [3:0] hourdec_now, hourone_now, mindec_now, minone_now, secdec_now, secone_now;
  logic [23:0] now_dig;

  typedef struct {
    int cyc;
    int tsec;
    bit mt;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;
  int   c0;

  time_counter #(
    .CLK_HZ (CLK_HZ)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .set_mode    (set_mode),
    .inc_min     (inc_min),
    .inc_hour    (inc_hour),
    .sec_tick    (sec_tick),
    .min_tick    (min_tick),
    .hourdec_now (hourdec_now),
    .hourone_now (hourone_now),
    .mindec_now  (mindec_now),
    .minone_now  (minone_now),
    .secdec_now  (secdec_now),
    .secone_now  (secone_now)
  );

  assign now_dig = {hourdec_now, hourone_now, mindec_now, minone_now, secdec_now, secone_now};

  always #5 clk = ~clk;

  // Posedge count; read only on negedges, where it is stable.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [23:0] digits_of(input int t);
    int h, m, s;
    h = t / 3600;
    m = (t / 60) % 60;
    s = t % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  // Queue n consecutive seconds starting after time t0, first due CLK_HZ cycles after cycle c.
  task automatic expect_run(input int c, input int t0, input int n);
    exp_t e;
    for (int k = 1; k <= n; k++) begin
      e.cyc  = c + CLK_HZ * k;
      e.tsec = (t0 + k) % DAY;
      e.mt   = ((t0 + k) % 60) == 0;
      exp_q.push_back(e);
    end
  endtask

  task automatic check_state(input string name, input int tsec, input logic st, input logic mt);
    checks++;
    if (now_dig !== digits_of(tsec) || sec_tick !== st || min_tick !== mt) begin
      errors++;
      $display("FAIL %s: got time %06h sec_tick=%b min_tick=%b, want time %06h sec_tick=%b min_tick=%b",
               name, now_dig, sec_tick, min_tick, digits_of(tsec), st, mt);
    end
  endtask

  task automatic pulse(input logic m, input logic h, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      inc_min  = m;
      inc_hour = h;
      @(negedge clk);
      inc_min  = 1'b0;
      inc_hour = 1'b0;
    end
  endtask

  // Monitor: every tick the DUT presents is matched against the queue head;
  // entries whose cycle has passed unmatched are missed ticks.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      checks++;
      errors++;
      $display("FAIL missed_tick: no sec_tick at cycle %0d (want time %06h), now cycle %0d",
               exp_q[0].cyc, digits_of(exp_q[0].tsec), cyc);
      void'(exp_q.pop_front());
    end
    if (sec_tick || min_tick) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_tick: cycle %0d sec_tick=%b min_tick=%b time %06h, want no tick",
                 cyc, sec_tick, min_tick, now_dig);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.cyc != cyc || now_dig !== digits_of(mon_e.tsec) ||
            sec_tick !== 1'b1 || min_tick !== mon_e.mt) begin
          errors++;
          $display("FAIL tick: got cycle %0d time %06h sec_tick=%b min_tick=%b, want cycle %0d time %06h sec_tick=1 min_tick=%b",
                   cyc, now_dig, sec_tick, min_tick, mon_e.cyc, digits_of(mon_e.tsec), mon_e.mt);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin
    // Reset, release, first second and first minute.
    #1 rstn = 1'b0;
    repeat (3) @(negedge clk);
    check_state("reset_state", 0, 1'b0, 1'b0);
    rstn = 1'b1;
    c0 = cyc;
    expect_run(c0, 0, 60);
    repeat (4) @(negedge clk);
    check_state("first_second", 1, 1'b1, 1'b0);
    repeat (236) @(negedge clk);
    check_state("first_minute", 60, 1'b1, 1'b1);

    // Set 23:59 and run through midnight.
    set_mode = 1'b1;
    pulse(1'b0, 1'b1, 23);
    pulse(1'b1, 1'b0, 58);
    check_state("set_23_59", 23 * 3600 + 59 * 60, 1'b0, 1'b0);
    set_mode = 1'b0;
    c0 = cyc;
    expect_run(c0, 23 * 3600 + 59 * 60, 60);
    repeat (236) @(negedge clk);
    check_state("at_23_59_59", DAY - 1, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    check_state("midnight_rollover", 0, 1'b1, 1'b1);

    // Set-mode wraps: minutes without hour carry, hours 23 -> 00.
    set_mode = 1'b1;
    pulse(1'b1, 1'b0, 58);
    check_state("set_00_58", 58 * 60, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 12);
    check_state("min_wrap_no_carry", 10 * 60, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 25);
    check_state("hour_wrap", 3600 + 10 * 60, 1'b0, 1'b0);

    // Coincident increments, then the same pulses ignored while running.
    pulse(1'b0, 1'b1, 8);
    pulse(1'b1, 1'b0, 49);
    check_state("set_09_59", 9 * 3600 + 59 * 60, 1'b0, 1'b0);
    pulse(1'b1, 1'b1, 1);
    check_state("both_inc", 10 * 3600, 1'b0, 1'b0);
    set_mode = 1'b0;
    c0 = cyc;
    expect_run(c0, 10 * 3600, 2);
    pulse(1'b1, 1'b1, 1);
    check_state("inc_ignored_running", 10 * 3600, 1'b0, 1'b0);

    // Enter set mode with the prescaler at 3: pending tick dropped, seconds cleared.
    repeat (9) @(negedge clk);
    set_mode = 1'b1;
    @(negedge clk);
    check_state("set_at_presc_3", 10 * 3600, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    set_mode = 1'b0;
    c0 = cyc;
    expect_run(c0, 10 * 3600, 1);
    repeat (3) @(negedge clk);
    check_state("no_early_tick", 10 * 3600, 1'b0, 1'b0);
    @(negedge clk);
    check_state("tick_after_set_exit", 10 * 3600 + 1, 1'b1, 1'b0);

    // Asynchronous reset mid-second at 05:07:33.
    set_mode = 1'b1;
    pulse(1'b0, 1'b1, 19);
    pulse(1'b1, 1'b0, 7);
    check_state("set_05_07", 5 * 3600 + 7 * 60, 1'b0, 1'b0);
    set_mode = 1'b0;
    c0 = cyc;
    expect_run(c0, 5 * 3600 + 7 * 60, 33);
    repeat (134) @(negedge clk);
    check_state("at_05_07_33", 5 * 3600 + 7 * 60 + 33, 1'b0, 1'b0);
    #2 rstn = 1'b0;
    #1 check_state("async_reset", 0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check_state("held_in_reset", 0, 1'b0, 1'b0);
    rstn = 1'b1;
    c0 = cyc;
    expect_run(c0, 0, 1);
    repeat (3) @(negedge clk);
    check_state("no_tick_before_4", 0, 1'b0, 1'b0);
    @(negedge clk);
    check_state("tick_after_reset", 1, 1'b1, 1'b0);
    repeat (2) @(negedge clk);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drained: %0d expected ticks outstanding, want 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
